// File: rtl/qrd_pkg.sv
// Shared definitions for the QRD input feeder: widths, matrix geometry,
// FSM state encoding and the complex sample type.
package qrd_pkg;
  localparam int unsigned IN_WIDTH_DEF = 14;
  localparam int          ONE_Q10_DEF  = 1024;
  localparam int unsigned N            = 4;
  localparam int unsigned STEPS        = 16;
  localparam int unsigned AUG_COLS     = 8;

  typedef enum logic {LOAD, ISSUE} state_t;

  typedef struct packed {
    logic signed [IN_WIDTH_DEF-1:0] r;
    logic signed [IN_WIDTH_DEF-1:0] i;
  } cplx_t;
endpackage

// File: rtl/qrd_skew_lane.sv
// One skewed row lane: registers augmented-matrix element A[LANE][step-LANE],
// inserting identity and zero columns, for the step about to be presented.
module qrd_skew_lane
  import qrd_pkg::*;
#(
  parameter int unsigned LANE = 0,
  parameter int unsigned W    = IN_WIDTH_DEF,
  parameter int          ONE  = ONE_Q10_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_active,
  input  logic [3:0]            i_step,
  input  logic [N-1:0][W-1:0]   i_row_r,
  input  logic [N-1:0][W-1:0]   i_row_i,
  output logic [W-1:0]          o_r,
  output logic [W-1:0]          o_i
);
  logic [4:0]   w_col;
  logic [W-1:0] w_r;
  logic [W-1:0] w_i;

  always_comb begin
    w_col = {1'b0, i_step} - 5'(LANE);
    w_r   = '0;
    w_i   = '0;
    if (i_active && ({1'b0, i_step} >= 5'(LANE)) && (w_col < 5'(AUG_COLS))) begin
      if (w_col < 5'(N)) begin
        w_r = i_row_r[w_col[1:0]];
        w_i = i_row_i[w_col[1:0]];
      end else if (w_col[1:0] == 2'(LANE)) begin
        w_r = W'(ONE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_r <= '0;
      o_i <= '0;
    end else begin
      o_r <= w_r;
      o_i <= w_i;
    end
  end
endmodule

// File: rtl/qrd_in_skew.sv
// Buffers one 4x4 complex matrix, then feeds [H | I] to the QRD core as four
// skewed row streams with row-start flags, stepping on in_ready.
module qrd_in_skew
  import qrd_pkg::*;
#(
  parameter int unsigned IN_WIDTH = IN_WIDTH_DEF,
  parameter int          ONE_Q10  = ONE_Q10_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [IN_WIDTH-1:0] s_data_r,
  input  logic signed [IN_WIDTH-1:0] s_data_i,
  input  logic                       in_ready,
  output logic signed [IN_WIDTH-1:0] row_in_1_r,
  output logic signed [IN_WIDTH-1:0] row_in_1_i,
  output logic signed [IN_WIDTH-1:0] row_in_2_r,
  output logic signed [IN_WIDTH-1:0] row_in_2_i,
  output logic signed [IN_WIDTH-1:0] row_in_3_r,
  output logic signed [IN_WIDTH-1:0] row_in_3_i,
  output logic signed [IN_WIDTH-1:0] row_in_4_r,
  output logic signed [IN_WIDTH-1:0] row_in_4_i,
  output logic                       row_in_1_f,
  output logic                       row_in_2_f,
  output logic                       row_in_3_f,
  output logic                       busy
);
  state_t                           r_state;
  state_t                           w_nxt_state;
  logic [3:0]                       r_k;
  logic [3:0]                       r_step;
  logic [3:0]                       w_nxt_step;
  logic                             w_accept;
  logic [N*N-1:0][IN_WIDTH-1:0]     r_buf_r;
  logic [N*N-1:0][IN_WIDTH-1:0]     r_buf_i;
  logic [N-1:0][IN_WIDTH-1:0]       w_lane_r;
  logic [N-1:0][IN_WIDTH-1:0]       w_lane_i;

  assign s_ready  = (r_state == LOAD);
  assign w_accept = s_valid && (r_state == LOAD);

  // Next step is computed ahead so lanes and flags can register the value
  // the outputs must show in the following cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_step  = r_step;
    case (r_state)
      LOAD: begin
        w_nxt_step = '0;
        if (w_accept && (r_k == 4'(N*N-1))) w_nxt_state = ISSUE;
      end
      ISSUE: begin
        if (in_ready) begin
          if (r_step == 4'(STEPS-1)) begin
            w_nxt_state = LOAD;
            w_nxt_step  = '0;
          end else begin
            w_nxt_step = r_step + 4'd1;
          end
        end
      end
      default: begin
        w_nxt_state = LOAD;
        w_nxt_step  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= LOAD;
      r_k        <= '0;
      r_step     <= '0;
      busy       <= 1'b0;
      row_in_1_f <= 1'b0;
      row_in_2_f <= 1'b0;
      row_in_3_f <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_step     <= w_nxt_step;
      busy       <= (w_nxt_state == ISSUE);
      row_in_1_f <= (w_nxt_state == ISSUE) && (w_nxt_step == 4'd0);
      row_in_2_f <= (w_nxt_state == ISSUE) && (w_nxt_step == 4'd2);
      row_in_3_f <= (w_nxt_state == ISSUE) && (w_nxt_step == 4'd4);
      if (w_accept) r_k <= r_k + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_r[r_k] <= s_data_r;
      r_buf_i[r_k] <= s_data_i;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    qrd_skew_lane #(
      .LANE(g),
      .W   (IN_WIDTH),
      .ONE (ONE_Q10)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_active(w_nxt_state == ISSUE),
      .i_step  (w_nxt_step),
      .i_row_r (r_buf_r[g*N +: N]),
      .i_row_i (r_buf_i[g*N +: N]),
      .o_r     (w_lane_r[g]),
      .o_i     (w_lane_i[g])
    );
  end

  assign row_in_1_r = w_lane_r[0];
  assign row_in_1_i = w_lane_i[0];
  assign row_in_2_r = w_lane_r[1];
  assign row_in_2_i = w_lane_i[1];
  assign row_in_3_r = w_lane_r[2];
  assign row_in_3_i = w_lane_i[2];
  assign row_in_4_r = w_lane_r[3];
  assign row_in_4_i = w_lane_i[3];
endmodule

// File: tb/tb_qrd_in_skew.sv
// Scoreboard bench for qrd_in_skew: a reference model expands each loaded
// matrix into its 16 expected steps; a negedge monitor consumes them.
module tb_qrd_in_skew;
  import qrd_pkg::*;
  localparam int W = 14;

  typedef struct packed {
    logic [3:0][W-1:0] r;
    logic [3:0][W-1:0] i;
    logic [2:0]        f;
  } obs_t;

  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, in_ready = 1'b1;
  logic [W-1:0] s_data_r = '0, s_data_i = '0;
  logic s_ready, busy, f1, f2, f3;
  logic [W-1:0] r1r, r1i, r2r, r2i, r3r, r3i, r4r, r4i;
  obs_t w_obs;

  obs_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0][W-1:0] mr, mi;

  always #5 clk = ~clk;

  qrd_in_skew #(.IN_WIDTH(W), .ONE_Q10(1024)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data_r(s_data_r), .s_data_i(s_data_i), .in_ready(in_ready),
    .row_in_1_r(r1r), .row_in_1_i(r1i), .row_in_2_r(r2r), .row_in_2_i(r2i),
    .row_in_3_r(r3r), .row_in_3_i(r3i), .row_in_4_r(r4r), .row_in_4_i(r4i),
    .row_in_1_f(f1), .row_in_2_f(f2), .row_in_3_f(f3), .busy(busy)
  );

  assign w_obs = {r4r, r3r, r2r, r1r, r4i, r3i, r2i, r1i, f3, f2, f1};

  function automatic void check(string name, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", name, got, exp);
  endfunction

  task automatic abort(string name);
    n_checks++;
    $display("FAIL %s timeout waiting on DUT", name);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // Reference: build [H | I], then lane r at step s shows column s-r if it exists.
  task automatic push_expected();
    logic [W-1:0] a_r[4][8];
    logic [W-1:0] a_i[4][8];
    obs_t o;
    int c;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 8; cc++) begin
        if (cc < 4) begin
          a_r[r][cc] = mr[4*r + cc];
          a_i[r][cc] = mi[4*r + cc];
        end else begin
          a_r[r][cc] = (cc - 4 == r) ? W'(1024) : '0;
          a_i[r][cc] = '0;
        end
      end
    for (int s = 0; s < 16; s++) begin
      o = '0;
      for (int r = 0; r < 4; r++) begin
        c = s - r;
        if (c >= 0 && c < 8) begin
          o.r[r] = a_r[r][c];
          o.i[r] = a_i[r][c];
        end
      end
      o.f = {s == 4, s == 2, s == 0};
      exp_q.push_back(o);
    end
  endtask

  always @(negedge clk) begin
    logic exp_busy;
    exp_busy = (exp_q.size() != 0);
    check("busy", busy, exp_busy);
    check("s_ready", s_ready, !exp_busy);
    if (exp_busy) begin
      check("step_out", w_obs, exp_q[0]);
      if (in_ready) void'(exp_q.pop_front());
    end else begin
      check("idle_zero", w_obs, '0);
    end
  end

  task automatic load_elems(input int count, input bit keep_valid);
    logic rdy;
    int t;
    for (int k = 0; k < count; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid  = 1'b0;
        s_data_r = W'($urandom);
        s_data_i = W'($urandom);
        @(posedge clk); #1;
      end
      s_data_r = mr[k];
      s_data_i = mi[k];
      s_valid  = 1'b1;
      t = 0;
      do begin
        @(negedge clk) rdy = s_ready;
        @(posedge clk); #1;
        t++;
      end while (!rdy && t < 400);
      if (!rdy) abort("load_wait");
    end
    if (!keep_valid) s_valid = 1'b0;
  endtask

  task automatic load_matrix(input bit keep_valid);
    load_elems(16, keep_valid);
    push_expected();
  endtask

  task automatic run_issue(input int stall_at, input int stall_len, input bit rnd);
    int cnt;
    int stalls;
    logic ir;
    cnt = 1;
    stalls = 0;
    forever begin
      if (rnd) ir = ($urandom_range(0, 3) != 0);
      else     ir = !(cnt >= stall_at && cnt < stall_at + stall_len);
      in_ready = ir;
      if (!ir) stalls++;
      @(posedge clk); #1;
      if (!busy) break;
      cnt++;
      if (cnt > 400) abort("issue_wait");
    end
    in_ready = 1'b1;
    check("issue_len", cnt, 16 + stalls);
  endtask

  task automatic rand_matrix(input bit extreme);
    for (int k = 0; k < 16; k++) begin
      if (extreme) begin
        mr[k] = $urandom_range(0, 1) ? 14'h1FFF : 14'h2000;
        mi[k] = $urandom_range(0, 1) ? 14'h1FFF : 14'h2000;
      end else begin
        mr[k] = W'($urandom);
        mi[k] = W'($urandom);
      end
    end
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1 check("rst_zero", {busy, s_ready, w_obs}, {1'b0, 1'b1, 115'd0});
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2 check("reset_state", {busy, s_ready, w_obs}, {1'b0, 1'b1, 115'd0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      mr[k] = W'(16 * (k / 4) + (k % 4) + 1);
      mi[k] = -mr[k];
    end
    load_matrix(1'b0);
    run_issue(0, 0, 1'b0);

    for (int n = 0; n < 2; n++) begin
      rand_matrix(1'b1);
      load_matrix(1'b0);
      run_issue(0, 0, 1'b0);
    end

    rand_matrix(1'b0);
    load_matrix(1'b0);
    run_issue(7, 5, 1'b0);

    rand_matrix(1'b0);
    load_matrix(1'b1);
    fork
      run_issue(0, 0, 1'b0);
      begin
        rand_matrix(1'b0);
        load_matrix(1'b0);
      end
    join
    run_issue(0, 0, 1'b0);

    rand_matrix(1'b0);
    load_matrix(1'b0);
    in_ready = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    reset_pulse();
    rand_matrix(1'b0);
    load_matrix(1'b0);
    run_issue(0, 0, 1'b0);

    rand_matrix(1'b0);
    load_elems(7, 1'b0);
    reset_pulse();
    rand_matrix(1'b0);
    load_matrix(1'b0);
    run_issue(0, 0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      rand_matrix(n[0]);
      load_matrix(1'b0);
      run_issue(0, 0, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
